// File: rtl/wb_clock_sync_if.sv
// Bus bundle for the narrow-to-wide Wishbone bridge.
// Signal names keep the Wishbone _i/_o suffixes as seen from the bridge.
// The "slave" modport is the bridge's view. It serves the upstream master on
// port A and the downstream slave on port B. The "master" modport is the view
// of the surrounding system.
interface wb_clock_sync_if #(
  parameter int CWIDTH  = 16,
  parameter int WWIDTH  = 32,
  parameter int ADDRESS = 25
);
  // Upstream (A) port, narrow.
  logic                  a_cyc_i;
  logic                  a_stb_i;
  logic                  a_we_i;
  logic                  a_ack_o;
  logic                  a_rty_o;
  logic                  a_err_o;
  logic [2:0]            a_cti_i;
  logic [1:0]            a_bte_i;
  logic [ADDRESS:0]      a_adr_i;
  logic [CWIDTH/8-1:0]   a_sel_i;
  logic [CWIDTH-1:0]     a_dat_i;
  logic [CWIDTH/8-1:0]   a_sel_o;
  logic [CWIDTH-1:0]     a_dat_o;

  // Downstream (B) port, wide.
  logic                  b_cyc_o;
  logic                  b_stb_o;
  logic                  b_we_o;
  logic                  b_ack_i;
  logic                  b_rty_i;
  logic                  b_err_i;
  logic [2:0]            b_cti_o;
  logic [1:0]            b_bte_o;
  logic [ADDRESS-1:0]    b_adr_o;
  logic [WWIDTH/8-1:0]   b_sel_i;
  logic [WWIDTH-1:0]     b_dat_i;
  logic [WWIDTH/8-1:0]   b_sel_o;
  logic [WWIDTH-1:0]     b_dat_o;

  modport slave (
    input  a_cyc_i, a_stb_i, a_we_i, a_cti_i, a_bte_i, a_adr_i, a_sel_i, a_dat_i,
    output a_ack_o, a_rty_o, a_err_o, a_sel_o, a_dat_o,
    output b_cyc_o, b_stb_o, b_we_o, b_cti_o, b_bte_o, b_adr_o, b_sel_o, b_dat_o,
    input  b_ack_i, b_rty_i, b_err_i, b_sel_i, b_dat_i
  );

  modport master (
    output a_cyc_i, a_stb_i, a_we_i, a_cti_i, a_bte_i, a_adr_i, a_sel_i, a_dat_i,
    input  a_ack_o, a_rty_o, a_err_o, a_sel_o, a_dat_o,
    input  b_cyc_o, b_stb_o, b_we_o, b_cti_o, b_bte_o, b_adr_o, b_sel_o, b_dat_o,
    output b_ack_i, b_rty_i, b_err_i, b_sel_i, b_dat_i
  );
endinterface

// File: rtl/wb_clock_sync.sv
// Registered Wishbone bridge from a narrow upstream master to a wide downstream bus.
// A single-word request is captured and replayed on the wide bus, with the lane
// selected by the low address bit. The matching half of the read data and the
// termination come back upstream in a one-cycle DONE slot.
module wb_clock_sync #(
  parameter int HIGHZ   = 0,
  parameter int CWIDTH  = 16,
  parameter int WWIDTH  = 2 * CWIDTH,
  parameter int ADDRESS = 25
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_clock_sync_if.slave bus
);
  localparam int SW  = CWIDTH / 8;
  localparam int WSW = WWIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  state_t              state_next;

  logic                busy;
  logic                done;
  logic                accept;
  logic                b_term;
  logic                half;
  logic                aborted;
  logic [2:0]          term;      // {err, rty, ack}, one-hot after priority

  logic                we;
  logic [ADDRESS:0]    adr;
  logic [SW-1:0]       sel;
  logic [CWIDTH-1:0]   dat;
  logic [2:0]          cti;
  logic [1:0]          bte;
  logic [CWIDTH-1:0]   rdat;
  logic [SW-1:0]       rsel;
  logic [WSW-1:0]      lane_sel;

  assign busy     = (state == BUSY);
  assign done     = (state == DONE);
  assign accept   = (state == IDLE) && bus.a_cyc_i && bus.a_stb_i;
  assign b_term   = bus.b_ack_i | bus.b_rty_i | bus.b_err_i;
  assign half     = adr[0];
  assign lane_sel = half ? {sel, {SW{1'b0}}} : {{SW{1'b0}}, sel};

  // State register; reset drops any transfer in flight without a termination.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_next;
  end

  // Next state: accept in IDLE, wait for any downstream termination, one DONE slot.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.a_cyc_i && bus.a_stb_i) state_next = BUSY;
      BUSY:    if (b_term) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Track an upstream abort and latch the prioritised termination kind.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      aborted <= 1'b0;
      term    <= 3'b000;
    end else begin
      if (accept)                      aborted <= 1'b0;
      else if (busy && !bus.a_cyc_i)   aborted <= 1'b1;
      if (busy && b_term) begin
        if (bus.b_err_i)      term <= 3'b100;
        else if (bus.b_rty_i) term <= 3'b010;
        else                  term <= 3'b001;
      end
    end
  end

  // Request and read-back registers; outputs are gated by state, so no reset needed.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      we  <= bus.a_we_i;
      adr <= bus.a_adr_i;
      sel <= bus.a_sel_i;
      dat <= bus.a_dat_i;
      cti <= bus.a_cti_i;
      bte <= bus.a_bte_i;
    end
    if (busy && b_term) begin
      rdat <= half ? bus.b_dat_i[WWIDTH-1:CWIDTH] : bus.b_dat_i[CWIDTH-1:0];
      rsel <= half ? bus.b_sel_i[WSW-1:SW]        : bus.b_sel_i[SW-1:0];
    end
  end

  assign bus.b_cyc_o = busy;
  assign bus.b_stb_o = busy;
  assign bus.a_ack_o = done && term[0] && !aborted;
  assign bus.a_rty_o = done && term[1] && !aborted;
  assign bus.a_err_o = done && term[2] && !aborted;

  // Shared-bus outputs either float or sit at zero outside their active phase.
  generate
    if (HIGHZ != 0) begin : g_tristate
      assign bus.b_we_o  = busy ? we              : 1'bz;
      assign bus.b_adr_o = busy ? adr[ADDRESS:1]  : {ADDRESS{1'bz}};
      assign bus.b_sel_o = busy ? lane_sel        : {WSW{1'bz}};
      assign bus.b_dat_o = busy ? {dat, dat}      : {WWIDTH{1'bz}};
      assign bus.b_cti_o = busy ? cti             : 3'bzzz;
      assign bus.b_bte_o = busy ? bte             : 2'bzz;
      assign bus.a_dat_o = done ? rdat            : {CWIDTH{1'bz}};
      assign bus.a_sel_o = done ? rsel            : {SW{1'bz}};
    end else begin : g_driven
      assign bus.b_we_o  = busy ? we              : 1'b0;
      assign bus.b_adr_o = busy ? adr[ADDRESS:1]  : {ADDRESS{1'b0}};
      assign bus.b_sel_o = busy ? lane_sel        : {WSW{1'b0}};
      assign bus.b_dat_o = busy ? {dat, dat}      : {WWIDTH{1'b0}};
      assign bus.b_cti_o = busy ? cti             : 3'b000;
      assign bus.b_bte_o = busy ? bte             : 2'b00;
      assign bus.a_dat_o = done ? rdat            : {CWIDTH{1'b0}};
      assign bus.a_sel_o = done ? rsel            : {SW{1'b0}};
    end
  endgenerate
endmodule

// File: tb/tb_wb_clock_sync.sv
// Bench for wb_clock_sync: a random upstream master and a random downstream
// responder. A transaction-level model predicts both buses every cycle.
module tb_wb_clock_sync;
  localparam int CW  = 16;
  localparam int WW  = 32;
  localparam int AW  = 25;
  localparam int SW  = CW / 8;
  localparam int WSW = WW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_clock_sync_if #(.CWIDTH(CW), .WWIDTH(WW), .ADDRESS(AW)) bus ();

  wb_clock_sync #(.HIGHZ(0), .CWIDTH(CW), .WWIDTH(WW), .ADDRESS(AW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Downstream responder controls.
  int         rsp_delay = -1;      // -1: random 0..3 wait cycles
  logic [2:0] rsp_kind  = 3'b000;  // {err,rty,ack}; 0: random mix
  bit         rsp_fixed = 1'b0;
  logic [WW-1:0]  rsp_dat = '0;
  logic [WSW-1:0] rsp_sel = '0;
  int         xfers = 0;           // terminations issued downstream

  initial begin
    int   wait_cnt;
    bit   in_xfer;
    int   r;
    in_xfer = 1'b0;
    wait_cnt = 0;
    bus.b_ack_i = 1'b0; bus.b_rty_i = 1'b0; bus.b_err_i = 1'b0;
    bus.b_dat_i = '0;   bus.b_sel_i = '0;
    forever begin
      @(posedge clk);
      #1;
      {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b000;
      bus.b_dat_i = WW'($urandom);
      bus.b_sel_i = WSW'($urandom_range(0, 15));
      if (rsp_fixed) begin
        bus.b_dat_i = rsp_dat;
        bus.b_sel_i = rsp_sel;
      end
      if (rst_n && bus.b_cyc_o && bus.b_stb_o) begin
        if (!in_xfer) begin
          in_xfer  = 1'b1;
          wait_cnt = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
        end
        if (wait_cnt == 0) begin
          if (rsp_kind != 3'b000) begin
            {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = rsp_kind;
          end else begin
            r = int'($urandom_range(0, 9));
            case (r)
              6:       {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b010;
              7:       {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b100;
              8:       {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b011;
              9:       {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b111;
              default: {bus.b_err_i, bus.b_rty_i, bus.b_ack_i} = 3'b001;
            endcase
          end
          in_xfer = 1'b0;
          xfers++;
        end else begin
          wait_cnt--;
        end
      end else begin
        in_xfer = 1'b0;
      end
    end
  end

  // Transaction-level model: one transfer outstanding at most, each finished
  // transfer owns exactly one reply cycle, and a new request is taken only when
  // neither is in progress.
  typedef struct packed {
    logic          we;
    logic [AW:0]   adr;
    logic [SW-1:0] sel;
    logic [CW-1:0] dat;
    logic [2:0]    cti;
    logic [1:0]    bte;
  } req_t;

  bit            xfer_open  = 1'b0;
  bit            reply_due  = 1'b0;
  bit            withdrawn  = 1'b0;
  req_t          cur;
  logic [2:0]    reply_kind;
  logic [CW-1:0] reply_dat;
  logic [SW-1:0] reply_sel;

  always @(negedge clk) begin
    logic [127:0]   act_b, exp_b, act_a, exp_a;
    logic [WSW-1:0] lane;
    logic [WW-1:0]  shifted;
    logic [WSW-1:0] sshift;
    bit             next_reply;
    act_b = 128'({bus.b_cyc_o, bus.b_stb_o, bus.b_we_o, bus.b_adr_o, bus.b_sel_o,
                  bus.b_dat_o, bus.b_cti_o, bus.b_bte_o});
    act_a = 128'({bus.a_err_o, bus.a_rty_o, bus.a_ack_o, bus.a_sel_o, bus.a_dat_o});
    if (!rst_n) begin
      check("reset_b_side", act_b, 128'(0));
      check("reset_a_side", act_a, 128'(0));
      xfer_open = 1'b0;
      reply_due = 1'b0;
      withdrawn = 1'b0;
    end else begin
      lane  = WSW'(cur.sel) << (cur.adr[0] ? SW : 0);
      exp_b = xfer_open ? 128'({2'b11, cur.we, cur.adr[AW:1], lane, cur.dat, cur.dat,
                                cur.cti, cur.bte}) : 128'(0);
      exp_a = reply_due ? 128'({reply_kind, reply_sel, reply_dat}) : 128'(0);
      check("b_side", act_b, exp_b);
      check("a_side", act_a, exp_a);
      // Advance to what the coming edge samples.
      next_reply = 1'b0;
      if (xfer_open) begin
        if (!bus.a_cyc_i) withdrawn = 1'b1;
        if (bus.b_ack_i || bus.b_rty_i || bus.b_err_i) begin
          shifted    = bus.b_dat_i >> (cur.adr[0] ? CW : 0);
          sshift     = bus.b_sel_i >> (cur.adr[0] ? SW : 0);
          reply_dat  = shifted[CW-1:0];
          reply_sel  = sshift[SW-1:0];
          reply_kind = bus.b_err_i ? 3'b100 : (bus.b_rty_i ? 3'b010 : 3'b001);
          if (withdrawn) reply_kind = 3'b000;
          xfer_open  = 1'b0;
          next_reply = 1'b1;
        end
      end else if (!reply_due && bus.a_cyc_i && bus.a_stb_i) begin
        cur       = '{we: bus.a_we_i, adr: bus.a_adr_i, sel: bus.a_sel_i, dat: bus.a_dat_i,
                      cti: bus.a_cti_i, bte: bus.a_bte_i};
        xfer_open = 1'b1;
        withdrawn = 1'b0;
      end
      reply_due = next_reply;
    end
  end

  typedef struct {
    logic [2:0]     term;
    logic [CW-1:0]  adat;
    logic [SW-1:0]  asel;
    logic [WW-1:0]  bdat;
    logic [WSW-1:0] bsel;
    logic [AW-1:0]  badr;
    logic           bwe;
    int             stb_at;
    int             term_at;
  } obs_t;

  // Present one request (called just after a rising edge) and wait for its termination.
  task automatic do_req(input logic we, input logic [AW:0] adr, input logic [SW-1:0] sel,
                        input logic [CW-1:0] dat, input bit hold, output obs_t o);
    o = '{term: 3'b000, adat: '0, asel: '0, bdat: '0, bsel: '0, badr: '0, bwe: 1'b0,
          stb_at: 0, term_at: 0};
    bus.a_cyc_i = 1'b1; bus.a_stb_i = 1'b1; bus.a_we_i = we;
    bus.a_adr_i = adr;  bus.a_sel_i = sel;  bus.a_dat_i = dat;
    bus.a_cti_i = 3'($urandom_range(0, 7));
    bus.a_bte_i = 2'($urandom_range(0, 3));
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.b_stb_o) begin
        if (o.stb_at == 0) o.stb_at = i;
        o.bwe  = bus.b_we_o;
        o.badr = bus.b_adr_o;
        o.bsel = bus.b_sel_o;
        o.bdat = bus.b_dat_o;
      end
      if (bus.a_ack_o || bus.a_rty_o || bus.a_err_o) begin
        o.term    = {bus.a_err_o, bus.a_rty_o, bus.a_ack_o};
        o.adat    = bus.a_dat_o;
        o.asel    = bus.a_sel_o;
        o.term_at = i;
        break;
      end
    end
    check("req_terminated", 128'(o.term != 3'b000), 128'(1));
    @(posedge clk);
    #1;
    if (!hold) begin
      bus.a_cyc_i = 1'b0;
      bus.a_stb_i = 1'b0;
    end
  endtask

  // Present a request, withdraw it after some busy cycles, wait for the bridge to drain.
  task automatic do_abort(input int busy_cycles, output int terms);
    terms = 0;
    bus.a_cyc_i = 1'b1; bus.a_stb_i = 1'b1;
    bus.a_we_i  = 1'($urandom_range(0, 1));
    bus.a_adr_i = (AW+1)'($urandom);
    bus.a_sel_i = SW'($urandom_range(0, 3));
    bus.a_dat_i = CW'($urandom);
    bus.a_cti_i = 3'($urandom_range(0, 7));
    bus.a_bte_i = 2'($urandom_range(0, 3));
    repeat (busy_cycles + 1) @(posedge clk);
    #1;
    bus.a_cyc_i = 1'b0;
    bus.a_stb_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.a_ack_o || bus.a_rty_o || bus.a_err_o) terms++;
      if (!bus.b_cyc_o) break;
    end
    check("abort_drain", 128'(bus.b_cyc_o), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, o2;
    int   x0, cnt, terms;
    bit   hold;
    rst_n = 1'b0;
    bus.a_cyc_i = 1'b0; bus.a_stb_i = 1'b0; bus.a_we_i = 1'b0;
    bus.a_adr_i = '0;   bus.a_sel_i = '0;   bus.a_dat_i = '0;
    bus.a_cti_i = '0;   bus.a_bte_i = '0;
    @(posedge clk);
    #1;
    check("reset_outputs", 128'({bus.b_cyc_o, bus.b_stb_o, bus.b_we_o, bus.a_ack_o,
                                 bus.a_rty_o, bus.a_err_o, bus.b_dat_o, bus.a_dat_o}), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read of the upper half, slave answers after three wait cycles.
    rsp_fixed = 1'b1; rsp_dat = 32'hDEADBEEF; rsp_sel = 4'b0110;
    rsp_delay = 3;    rsp_kind = 3'b001;
    do_req(1'b0, 26'h0000001, 2'b11, 16'h0000, 1'b0, o);
    check("rd_hi_badr", 128'(o.badr), 128'(0));
    check("rd_hi_bsel", 128'(o.bsel), 128'(4'b1100));
    check("rd_hi_bwe",  128'(o.bwe),  128'(0));
    check("rd_hi_term", 128'(o.term), 128'(3'b001));
    check("rd_hi_adat", 128'(o.adat), 128'(16'hDEAD));
    check("rd_hi_asel", 128'(o.asel), 128'(2'b01));
    check("rd_hi_stb_at", 128'(o.stb_at), 128'(2));
    check("rd_hi_ack_at", 128'(o.term_at), 128'(6));

    // Read of the lower half with an immediate acknowledge: minimum latency.
    rsp_delay = 0;
    do_req(1'b0, 26'h0000002, 2'b11, 16'h0000, 1'b0, o);
    check("rd_lo_badr", 128'(o.badr), 128'(1));
    check("rd_lo_bsel", 128'(o.bsel), 128'(4'b0011));
    check("rd_lo_adat", 128'(o.adat), 128'(16'hBEEF));
    check("rd_lo_asel", 128'(o.asel), 128'(2'b10));
    check("rd_lo_ack_at", 128'(o.term_at), 128'(3));

    // Write to the upper half with a single byte lane.
    rsp_delay = 1;
    do_req(1'b1, 26'h0000003, 2'b01, 16'h1234, 1'b0, o);
    check("wr_bwe",  128'(o.bwe),  128'(1));
    check("wr_bdat", 128'(o.bdat), 128'(32'h12341234));
    check("wr_bsel", 128'(o.bsel), 128'(4'b0100));
    check("wr_badr", 128'(o.badr), 128'(1));
    check("wr_term", 128'(o.term), 128'(3'b001));

    // Back-to-back writes with the strobe held across the acknowledge.
    rsp_delay = 0;
    x0 = xfers;
    do_req(1'b1, 26'h0000004, 2'b11, 16'hAAAA, 1'b1, o);
    do_req(1'b1, 26'h0000005, 2'b10, 16'h5555, 1'b0, o2);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_xfers", 128'(xfers - x0), 128'(2));
    check("b2b_first_bdat",  128'(o.bdat),  128'(32'hAAAAAAAA));
    check("b2b_second_bdat", 128'(o2.bdat), 128'(32'h55555555));
    check("b2b_second_bsel", 128'(o2.bsel), 128'(4'b1000));
    check("b2b_second_gap",  128'(o2.stb_at), 128'(2));

    // Error and retry terminations, including several asserted at once.
    rsp_kind = 3'b100;
    do_req(1'b0, 26'h0000010, 2'b11, 16'h0, 1'b0, o);
    check("err_term", 128'(o.term), 128'(3'b100));
    rsp_kind = 3'b010;
    do_req(1'b0, 26'h0000011, 2'b11, 16'h0, 1'b0, o);
    check("rty_term", 128'(o.term), 128'(3'b010));
    rsp_kind = 3'b111;
    do_req(1'b1, 26'h0000012, 2'b01, 16'h0F0F, 1'b0, o);
    check("all_term_prio", 128'(o.term), 128'(3'b100));
    rsp_kind = 3'b011;
    do_req(1'b0, 26'h0000013, 2'b11, 16'h0, 1'b0, o);
    check("rty_ack_prio", 128'(o.term), 128'(3'b010));

    // Upstream withdraws mid-transfer: downstream completes, no reply upstream.
    rsp_kind = 3'b001; rsp_delay = 3;
    x0 = xfers;
    do_abort(1, terms);
    check("abort_no_term", 128'(terms), 128'(0));
    check("abort_xfer_done", 128'(xfers - x0), 128'(1));

    // Reset while the downstream transfer is waiting.
    rsp_delay = 10;
    bus.a_cyc_i = 1'b1; bus.a_stb_i = 1'b1; bus.a_we_i = 1'b0;
    bus.a_adr_i = 26'h0000020; bus.a_sel_i = 2'b11;
    repeat (2) @(posedge clk);
    #3;
    check("pre_reset_busy", 128'({bus.b_cyc_o, bus.b_stb_o}), 128'(2'b11));
    rst_n = 1'b0;
    #1;
    check("reset_mid_busy", 128'({bus.b_cyc_o, bus.b_stb_o}), 128'(0));
    bus.a_cyc_i = 1'b0; bus.a_stb_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.a_ack_o || bus.a_rty_o || bus.a_err_o || bus.b_stb_o) cnt++;
    end
    check("reset_no_activity", 128'(cnt), 128'(0));
    @(posedge clk);
    #1;

    // Randomised traffic against the model.
    rsp_fixed = 1'b0; rsp_delay = -1; rsp_kind = 3'b000;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_abort(int'($urandom_range(0, 2)), terms);
      end else begin
        hold = 1'($urandom_range(0, 1));
        do_req(1'($urandom_range(0, 1)), (AW+1)'($urandom), SW'($urandom_range(0, 3)),
               CW'($urandom), hold, o);
        if (!hold) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
    end
    bus.a_cyc_i = 1'b0; bus.a_stb_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
